// File: rtl/jtag_reg_access.sv
// Debug-port access controller: turns single JTAG read/write commands into register-file
// debug-port cycles, retrying writes that lose to a same-address execute-stage writeback.
module jtag_reg_access #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int RETRY_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_err_o,
    output logic              jtag_we_o,
    output logic [ADDR_W-1:0] jtag_addr_o,
    output logic [DATA_W-1:0] jtag_data_o,
    input  logic [DATA_W-1:0] jtag_data_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_waddr_i
);

    localparam int CNT_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  retry_r, retry_nxt_s;
    logic              jtag_we_r, jtag_we_nxt_s;
    logic [ADDR_W-1:0] jtag_addr_r, jtag_addr_nxt_s;
    logic [DATA_W-1:0] jtag_data_r, jtag_data_nxt_s;
    logic              resp_valid_r, resp_valid_nxt_s;
    logic [DATA_W-1:0] resp_data_r, resp_data_nxt_s;
    logic              resp_err_r, resp_err_nxt_s;
    logic              collision_s;

    // Writeback to the same register this cycle wins at the register file.
    assign collision_s = core_we_i && (core_waddr_i == jtag_addr_r);

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            retry_r      <= {CNT_W{1'b0}};
            jtag_we_r    <= 1'b0;
            jtag_addr_r  <= {ADDR_W{1'b0}};
            jtag_data_r  <= {DATA_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_data_r  <= {DATA_W{1'b0}};
            resp_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            retry_r      <= retry_nxt_s;
            jtag_we_r    <= jtag_we_nxt_s;
            jtag_addr_r  <= jtag_addr_nxt_s;
            jtag_data_r  <= jtag_data_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_data_r  <= resp_data_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s      = state_r;
        retry_nxt_s      = retry_r;
        jtag_we_nxt_s    = 1'b0;
        jtag_addr_nxt_s  = jtag_addr_r;
        jtag_data_nxt_s  = jtag_data_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_data_nxt_s  = resp_data_r;
        resp_err_nxt_s   = resp_err_r;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    jtag_addr_nxt_s = req_addr_i;
                    jtag_data_nxt_s = req_data_i;
                    retry_nxt_s     = {CNT_W{1'b0}};
                    if (req_we_i && (req_addr_i == {ADDR_W{1'b0}})) begin
                        // x0 is hardwired; reject without touching the register file.
                        state_nxt_s      = RESP;
                        resp_valid_nxt_s = 1'b1;
                        resp_err_nxt_s   = 1'b1;
                        resp_data_nxt_s  = {DATA_W{1'b0}};
                    end else if (req_we_i) begin
                        state_nxt_s   = WR;
                        jtag_we_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR: begin
                if (collision_s && (retry_r != RETRY_LAST)) begin
                    retry_nxt_s   = retry_r + CNT_ONE;
                    jtag_we_nxt_s = 1'b1;
                end else if (collision_s) begin
                    state_nxt_s      = RESP;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = 1'b1;
                    resp_data_nxt_s  = jtag_data_r;
                end else begin
                    state_nxt_s      = RESP;
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = 1'b0;
                    resp_data_nxt_s  = jtag_data_r;
                end
            end
            RD: begin
                state_nxt_s      = RESP;
                resp_valid_nxt_s = 1'b1;
                resp_err_nxt_s   = 1'b0;
                resp_data_nxt_s  = jtag_data_i;
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_nxt_s      = IDLE;
                    resp_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                resp_valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign req_ready_o  = (state_r == IDLE) && !rst;
    assign resp_valid_o = resp_valid_r;
    assign resp_data_o  = resp_data_r;
    assign resp_err_o   = resp_err_r;
    assign jtag_we_o    = jtag_we_r;
    assign jtag_addr_o  = jtag_addr_r;
    assign jtag_data_o  = jtag_data_r;

endmodule

// File: tb/tb_jtag_reg_access.sv
// Directed bench for jtag_reg_access with a small register-file model
// (writeback priority on same-address collision, read bypass, x0 hardwired).
module tb_jtag_reg_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_data = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        jtag_we;
    logic [4:0]  jtag_addr;
    logic [31:0] jtag_data_out;
    logic [31:0] jtag_rdata;
    logic        core_we = 1'b0;
    logic [4:0]  core_waddr = 5'd0;
    logic [31:0] core_wdata = 32'd0;

    logic [31:0] regs [32];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    jtag_reg_access #(.ADDR_W(5), .DATA_W(32), .RETRY_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_data_o(resp_data), .resp_err_o(resp_err),
        .jtag_we_o(jtag_we), .jtag_addr_o(jtag_addr), .jtag_data_o(jtag_data_out),
        .jtag_data_i(jtag_rdata),
        .core_we_i(core_we), .core_waddr_i(core_waddr)
    );

    // Register file: writeback wins a same-address collision; x0 never changes.
    always @(posedge clk) begin
        if (core_we && core_waddr != 5'd0)
            regs[core_waddr] <= core_wdata;
        if (jtag_we && jtag_addr != 5'd0 && !(core_we && core_waddr == jtag_addr))
            regs[jtag_addr] <= jtag_data_out;
    end

    // Combinational debug read with writeback bypass.
    always_comb begin
        if (jtag_addr == 5'd0)
            jtag_rdata = 32'd0;
        else if (core_we && core_waddr == jtag_addr)
            jtag_rdata = core_wdata;
        else
            jtag_rdata = regs[jtag_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; the core writes the target register for `hits` cycles
    // starting in the first cycle after acceptance; response held for `hold` cycles.
    task automatic run_cmd(input logic we, input logic [4:0] addr, input logic [31:0] data,
                           input int hits, input logic [31:0] core_val, input int hold,
                           output int lat, output int we_cycles,
                           output logic [31:0] rdata, output logic err);
        logic [31:0] held;
        lat = 0;
        we_cycles = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (jtag_we) we_cycles++;
            if (hits > 0) begin
                core_we = 1'b1; core_waddr = addr; core_wdata = core_val + 32'(hits);
                hits--;
            end else begin
                core_we = 1'b0;
            end
            step();
            lat++;
        end
        core_we = 1'b0;
        check_eq("resp_timeout", 32'(lat < 20), 32'd1);
        rdata = resp_data;
        err = resp_err;
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_data = 32'hBAD0BAD0;
            step();
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_data", resp_data, held);
            check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_eq("post_valid", 32'(resp_valid), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
    endtask

    int lat, wec;
    logic [31:0] rd;
    logic er;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_we", 32'(jtag_we), 32'd0);
        check_eq("rst_addr", 32'(jtag_addr), 32'd0);
        check_eq("rst_data", resp_data, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_eq("idle_ready", 32'(req_ready), 32'd1);

        // Plain write then read back.
        run_cmd(1'b1, 5'd5, 32'hDEADBEEF, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("wr5_lat", 32'(lat), 32'd2);
        check_eq("wr5_we", 32'(wec), 32'd1);
        check_eq("wr5_data", rd, 32'hDEADBEEF);
        check_eq("wr5_err", 32'(er), 32'd0);
        run_cmd(1'b0, 5'd5, 32'd0, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("rd5_lat", 32'(lat), 32'd2);
        check_eq("rd5_data", rd, 32'hDEADBEEF);
        check_eq("rd5_err", 32'(er), 32'd0);

        // x0 read and rejected write.
        run_cmd(1'b0, 5'd0, 32'd0, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("rd0_data", rd, 32'd0);
        check_eq("rd0_err", 32'(er), 32'd0);
        run_cmd(1'b1, 5'd0, 32'h00001234, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("wr0_lat", 32'(lat), 32'd1);
        check_eq("wr0_we", 32'(wec), 32'd0);
        check_eq("wr0_data", rd, 32'd0);
        check_eq("wr0_err", 32'(er), 32'd1);

        // Two collisions: retried and committed.
        run_cmd(1'b1, 5'd7, 32'hA5A5A5A5, 2, 32'h70000000, 0, lat, wec, rd, er);
        check_eq("wr7c2_lat", 32'(lat), 32'd4);
        check_eq("wr7c2_we", 32'(wec), 32'd3);
        check_eq("wr7c2_err", 32'(er), 32'd0);
        check_eq("wr7c2_data", rd, 32'hA5A5A5A5);
        run_cmd(1'b0, 5'd7, 32'd0, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("rd7a_data", rd, 32'hA5A5A5A5);

        // Four collisions: retries exhausted, core's last value survives.
        run_cmd(1'b1, 5'd7, 32'h11112222, 4, 32'h70000000, 0, lat, wec, rd, er);
        check_eq("wr7c4_lat", 32'(lat), 32'd5);
        check_eq("wr7c4_we", 32'(wec), 32'd4);
        check_eq("wr7c4_err", 32'(er), 32'd1);
        run_cmd(1'b0, 5'd7, 32'd0, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("rd7b_data", rd, 32'h70000001);

        // Read with same-cycle writeback sees the bypassed value.
        run_cmd(1'b0, 5'd9, 32'd0, 1, 32'h90000000, 0, lat, wec, rd, er);
        check_eq("rd9_byp", rd, 32'h90000001);

        // Back-pressured response; commands offered meanwhile must be ignored.
        run_cmd(1'b1, 5'd3, 32'h33333333, 0, 32'd0, 0, lat, wec, rd, er);
        run_cmd(1'b0, 5'd3, 32'd0, 0, 32'd0, 5, lat, wec, rd, er);
        check_eq("rd3_data", rd, 32'h33333333);
        run_cmd(1'b0, 5'd3, 32'd0, 0, 32'd0, 0, lat, wec, rd, er);
        check_eq("rd3_again", rd, 32'h33333333);

        // Reset asserted during WR.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd6; req_data = 32'h66666666;
        step();
        req_valid = 1'b0;
        core_we = 1'b1; core_waddr = 5'd6; core_wdata = 32'h60000000;
        check_eq("mid_we_before", 32'(jtag_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_we_async", 32'(jtag_we), 32'd0);
        check_eq("mid_valid_async", 32'(resp_valid), 32'd0);
        check_eq("mid_ready_rst", 32'(req_ready), 32'd0);
        core_we = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_valid", 32'(resp_valid), 32'd0);
            check_eq("post_rst_ready", 32'(req_ready), 32'd1);
            check_eq("post_rst_we", 32'(jtag_we), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
